xc_sha3_lane_seq: RTL

Parametrised, sequential successor to the combinational xc_sha3 lane-index unit. It walks a Keccak lane grid in one of three modes and emits one scaled lane index per handshake, so the datapath can stream the state without per-lane index instructions. Modes are full-grid scan with an arbitrary x offset, a single row, and the rho/pi chain. It sits beside the SHA3 unit and feeds a load/store or register-file address port through a valid/ready interface.

---
 rtl/xc_sha3_pkg.sv | 33 +++
 rtl/xc_sha3_lane_step.sv | 53 +++++
 rtl/xc_sha3_lane_seq.sv | 131 +++++++++++++
 3 files changed

// File: rtl/xc_sha3_pkg.sv
// Shared definitions for the sequential SHA3 lane-index walker.
//   mode_e   : walk pattern (SCAN / ROW / CHAIN; encoding 3 folds into SCAN)
//   state_e  : walker FSM state (IDLE / RUN)
//   mod_dim  : narrow compare-and-subtract reduction, valid for v < 8*d
package xc_sha3_pkg;

  typedef enum logic [1:0] {
    MODE_SCAN  = 2'd0,
    MODE_ROW   = 2'd1,
    MODE_CHAIN = 2'd2
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Coordinate width (DIM <= 7) and raw lane-index width (DIM*DIM-1 <= 48).
  localparam int CW = 3;
  localparam int IW = 8;

  // Three conditional subtracts (4d, 2d, d) bring anything below 8*d into
  // [0, d). Every caller stays below 5*d, so no divider is needed.
  function automatic logic [CW-1:0] mod_dim(input logic [7:0] v, input logic [7:0] d);
    logic [7:0] r;
    r = v;
    if (r >= {d[5:0], 2'b00}) r = r - {d[5:0], 2'b00};
    if (r >= {d[6:0], 1'b0})  r = r - {d[6:0], 1'b0};
    if (r >= d)               r = r - d;
    return r[CW-1:0];
  endfunction

endpackage

// File: rtl/xc_sha3_lane_step.sv
// Combinational step of the lane walk: given the current coordinate and the
// latched mode/offset, produce this element's lane index and the next (x,y).
//   mode    : latched walk mode (MODE_SCAN / MODE_ROW / MODE_CHAIN)
//   x, y    : current coordinate, both already < DIM
//   xoff    : latched x offset, already < DIM
//   idx     : lane index of the current element (unshifted)
//   nx, ny  : coordinate of the following element
module xc_sha3_lane_step
  import xc_sha3_pkg::*;
#(
  parameter int DIM = 5
) (
  input  logic [1:0]    mode,
  input  logic [CW-1:0] x,
  input  logic [CW-1:0] y,
  input  logic [CW-1:0] xoff,
  output logic [IW-1:0] idx,
  output logic [CW-1:0] nx,
  output logic [CW-1:0] ny
);

  localparam logic [7:0] D8 = 8'(DIM);

  logic [CW-1:0] xs;
  logic [CW-1:0] chain_y;
  logic [7:0]    row_base;
  logic          x_wrap;

  always_comb begin
    // x+xoff < 2*DIM; 2x+3y < 5*DIM -- both inside mod_dim's range.
    xs       = mod_dim(8'(x) + 8'(xoff), D8);
    chain_y  = mod_dim(8'(x) * 8'd2 + 8'(y) * 8'd3, D8);
    row_base = 8'(y) * D8;
    x_wrap   = (8'(x) == D8 - 8'd1);

    idx = (mode == MODE_CHAIN) ? 8'(x) + row_base : 8'(xs) + row_base;

    nx = x_wrap ? '0 : x + CW'(1);
    ny = y;
    case (mode)
      MODE_CHAIN: begin
        nx = y;
        ny = chain_y;
      end
      MODE_ROW: ;
      default: begin
        // y may step to DIM after the final element; it is never emitted.
        if (x_wrap) ny = y + CW'(1);
      end
    endcase
  end

endmodule

// File: rtl/xc_sha3_lane_seq.sv
// Sequential Keccak lane-index walker. A start in IDLE latches the
// configuration; one scaled lane index is then offered per valid/ready
// handshake until the element flagged out_last is taken.
//   clock, reset       : rising-edge clock, async active-low reset
//   start              : begin a walk (sampled in IDLE only)
//   mode               : 0 SCAN, 1 ROW, 2 CHAIN, 3 treated as SCAN
//   xoff, x0, y0       : offsets / start coordinate, reduced mod DIM at latch
//   shamt              : left shift applied to each emitted index
//   busy               : walk in progress
//   out_valid/out_ready: output handshake
//   out_idx, out_last  : scaled lane index and final-element flag
//   done               : one-cycle pulse after the final handshake
module xc_sha3_lane_seq
  import xc_sha3_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int DIM  = 5,
  parameter int SHW  = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      mode,
  input  logic [2:0]      xoff,
  input  logic [2:0]      x0,
  input  logic [2:0]      y0,
  input  logic [SHW-1:0]  shamt,
  output logic            busy,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_idx,
  output logic            out_last,
  output logic            done
);

  localparam int             CNTW       = $clog2(DIM * DIM);
  localparam logic [7:0]     D8         = 8'(DIM);
  localparam logic [CNTW-1:0] LAST_SCAN  = CNTW'(DIM * DIM - 1);
  localparam logic [CNTW-1:0] LAST_ROW   = CNTW'(DIM - 1);
  localparam logic [CNTW-1:0] LAST_CHAIN = CNTW'(DIM * DIM - 2);

  state_e          state_q, state_d;
  logic [1:0]      mode_q, mode_n;
  logic [CW-1:0]   xoff_q, x_q, y_q;
  logic [CW-1:0]   xoff_n, x0_n, y0_n;
  logic [SHW-1:0]  shamt_q;
  logic [CNTW-1:0] cnt_q, last_cnt;
  logic            done_q;
  logic [IW-1:0]   idx;
  logic [CW-1:0]   nx, ny;
  logic            accept, hs, is_last;

  xc_sha3_lane_step #(.DIM(DIM)) u_step (
    .mode (mode_q),
    .x    (x_q),
    .y    (y_q),
    .xoff (xoff_q),
    .idx  (idx),
    .nx   (nx),
    .ny   (ny)
  );

  // Input reduction at latch time keeps every stored coordinate < DIM.
  always_comb begin
    mode_n = (mode == 2'd3) ? MODE_SCAN : mode;
    xoff_n = mod_dim(8'(xoff), D8);
    x0_n   = mod_dim(8'(x0), D8);
    y0_n   = mod_dim(8'(y0), D8);
  end

  always_comb begin
    case (mode_q)
      MODE_ROW:   last_cnt = LAST_ROW;
      MODE_CHAIN: last_cnt = LAST_CHAIN;
      default:    last_cnt = LAST_SCAN;
    endcase
  end

  assign accept  = (state_q == ST_IDLE) && start;
  assign hs      = out_valid && out_ready;
  assign is_last = (cnt_q == last_cnt);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start)         state_d = ST_RUN;
      ST_RUN:  if (hs && is_last) state_d = ST_IDLE;
      default:                    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mode_q  <= MODE_SCAN;
      xoff_q  <= '0;
      shamt_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= hs && is_last;
      if (accept) begin
        mode_q  <= mode_n;
        xoff_q  <= xoff_n;
        shamt_q <= shamt;
        cnt_q   <= '0;
        x_q     <= (mode_n == MODE_CHAIN) ? x0_n : '0;
        y_q     <= (mode_n == MODE_SCAN)  ? '0   : y0_n;
      end else if (hs) begin
        x_q   <= nx;
        y_q   <= ny;
        cnt_q <= cnt_q + CNTW'(1);
      end
    end
  end

  // Outputs decode from registers only, so they hold while a stall persists.
  // The index is widened before shifting so no bits fall off for XLEN >= 8.
  assign busy      = (state_q == ST_RUN);
  assign out_valid = (state_q == ST_RUN);
  assign out_last  = out_valid && is_last;
  assign out_idx   = out_valid ? (XLEN'(idx) << shamt_q) : '0;
  assign done      = done_q;

endmodule
